// File: rtl/pc_fetch_sequencer_pkg.sv
`default_nettype none
// ============================================================================
// Module      : pc_fetch_sequencer_pkg
// Description : Shared types and constants for the IF-stage fetch sequencer.
// Revision    : 1.0 - initial release
// ============================================================================
package pc_fetch_sequencer_pkg;

    typedef enum logic [1:0] {
        S_RUN           = 2'd0,
        S_WAIT_MEM      = 2'd1,
        S_REDIRECT_PEND = 2'd2
    } fetch_state_e;

    localparam logic [31:0] C_RESET_VECTOR = 32'h0000_0000;
    localparam logic [31:0] C_TRAP_VECTOR  = 32'h0000_0100;
    localparam logic [31:0] C_NOP          = 32'h0000_0013;
    localparam logic [31:0] C_PC_STEP      = 32'd4;

    // Instruction addresses must be word aligned.
    function automatic logic is_aligned(input logic [31:0] addr);
        return (addr[1:0] == 2'b00);
    endfunction

endpackage
`default_nettype wire

// File: rtl/pc_fetch_sequencer_if.sv
`default_nettype none
// ============================================================================
// Module      : pc_fetch_sequencer_if
// Description : Redirect/hazard inputs and fetch outputs of the IF sequencer.
// Revision    : 1.0 - initial release
// ============================================================================
interface pc_fetch_sequencer_if;

    logic        PCAddressController;
    logic [31:0] TargetedAddress;
    logic        Stall;
    logic        IMemBusyWait;
    logic [31:0] PC;
    logic [31:0] PCPlus4;
    logic        IMemRead;
    logic        FetchValid;
    logic        IFIDFlush;
    logic        IDEXFlush;
    logic        MisalignFault;

    // Sequencer side: owns the PC and drives the fetch and flush outputs.
    modport master (
        input  PCAddressController,
        input  TargetedAddress,
        input  Stall,
        input  IMemBusyWait,
        output PC,
        output PCPlus4,
        output IMemRead,
        output FetchValid,
        output IFIDFlush,
        output IDEXFlush,
        output MisalignFault
    );

    modport slave (
        output PCAddressController,
        output TargetedAddress,
        output Stall,
        output IMemBusyWait,
        input  PC,
        input  PCPlus4,
        input  IMemRead,
        input  FetchValid,
        input  IFIDFlush,
        input  IDEXFlush,
        input  MisalignFault
    );

endinterface
`default_nettype wire

// File: rtl/pc_fetch_sequencer_redirect_latch.sv
`default_nettype none
// ============================================================================
// Module      : pc_redirect_latch
// Description : Holds a redirect target accepted while a fetch is outstanding.
// Revision    : 1.0 - initial release
// ============================================================================
module pc_redirect_latch (
    input  wire logic        clk,
    input  wire logic        rst,
    input  wire logic        i_load,
    input  wire logic        i_clear,
    input  wire logic [31:0] i_target,
    output logic             o_valid,
    output logic [31:0]      o_target
);

    logic        r_valid;
    logic [31:0] r_target;

    // Clear wins over load so a completing redirect can never be re-armed.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_valid  <= 1'b0;
            r_target <= 32'h0000_0000;
        end else if (i_clear) begin
            r_valid  <= 1'b0;
        end else if (i_load) begin
            r_valid  <= 1'b1;
            r_target <= i_target;
        end
    end

    assign o_valid  = r_valid;
    assign o_target = r_target;

endmodule
`default_nettype wire

// File: rtl/pc_fetch_sequencer.sv
`default_nettype none
// ============================================================================
// Module      : pc_fetch_sequencer
// Description : IF-stage PC owner: sequential fetch, redirects, wrong-path flush.
// Revision    : 1.0 - initial release
// ============================================================================
module pc_fetch_sequencer
    import pc_fetch_sequencer_pkg::*;
#(
    parameter logic [31:0] RESET_VECTOR = C_RESET_VECTOR,
    parameter logic [31:0] TRAP_VECTOR  = C_TRAP_VECTOR
) (
    input  wire logic             CLK,
    input  wire logic             RESET,
    pc_fetch_sequencer_if.master  bus
);

    fetch_state_e r_state;
    fetch_state_e w_state_next;

    logic [31:0] r_pc;
    logic [31:0] w_pc_next;
    logic [31:0] w_pc_plus4;
    logic        r_flush;
    logic        r_misalign;

    logic        w_accept;
    logic        w_misalign;
    logic [31:0] w_target;
    logic        w_fetch_valid;
    logic        w_pend_load;
    logic        w_pend_clear;
    logic        w_pend_valid;
    logic [31:0] w_pend_target;

    assign w_pc_plus4 = r_pc + C_PC_STEP;

    // Once a redirect is latched, younger redirects come from wrong-path code.
    assign w_accept   = bus.PCAddressController && (r_state != S_REDIRECT_PEND);
    assign w_misalign = !is_aligned(bus.TargetedAddress);
    assign w_target   = w_misalign ? TRAP_VECTOR : bus.TargetedAddress;

    pc_redirect_latch u_redirect_latch (
        .clk      (CLK),
        .rst      (RESET),
        .i_load   (w_pend_load),
        .i_clear  (w_pend_clear),
        .i_target (w_target),
        .o_valid  (w_pend_valid),
        .o_target (w_pend_target)
    );

    always_ff @(posedge CLK) begin
        if (RESET) begin
            r_state    <= S_RUN;
            r_pc       <= RESET_VECTOR;
            r_flush    <= 1'b0;
            r_misalign <= 1'b0;
        end else begin
            r_state    <= w_state_next;
            r_pc       <= w_pc_next;
            r_flush    <= w_accept;
            r_misalign <= w_accept && w_misalign;
        end
    end

    always_comb begin
        w_state_next  = r_state;
        w_pc_next     = r_pc;
        w_pend_load   = 1'b0;
        w_pend_clear  = 1'b0;
        w_fetch_valid = 1'b0;

        case (r_state)
            S_RUN, S_WAIT_MEM: begin
                if (w_accept) begin
                    // The word at PC is wrong-path; it never reports valid.
                    if (bus.IMemBusyWait) begin
                        w_pend_load  = 1'b1;
                        w_state_next = S_REDIRECT_PEND;
                    end else begin
                        w_pc_next    = w_target;
                        w_state_next = S_RUN;
                    end
                end else if (bus.IMemBusyWait) begin
                    w_state_next = S_WAIT_MEM;
                end else begin
                    w_state_next  = S_RUN;
                    w_fetch_valid = 1'b1;
                    if (!bus.Stall) begin
                        w_pc_next = w_pc_plus4;
                    end
                end
            end

            S_REDIRECT_PEND: begin
                if (!bus.IMemBusyWait) begin
                    if (w_pend_valid) begin
                        w_pc_next = w_pend_target;
                    end
                    w_pend_clear = 1'b1;
                    w_state_next = S_RUN;
                end
            end

            default: begin
                w_state_next = S_RUN;
            end
        endcase
    end

    assign bus.PC            = r_pc;
    assign bus.PCPlus4       = w_pc_plus4;
    assign bus.IMemRead      = !RESET;
    assign bus.FetchValid    = !RESET && w_fetch_valid;
    assign bus.IFIDFlush     = r_flush;
    assign bus.IDEXFlush     = r_flush;
    assign bus.MisalignFault = r_misalign;

endmodule
`default_nettype wire
